alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the team's 4-bit combinational ALU.
- Configurable operand width; original 8 operations keep their opcodes; adds shifts, carry-chained add/subtract, compare and pass-through.
- Adds status flags and a registered carry flag for multi-word arithmetic.
- Sits between an issue source and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand/result width in bits, minimum 4.
- SHW, $clog2(WIDTH), shift-amount width (derived), taken from B[SHW-1:0].

Ports:
- clk  in  1  sole clock; all logic updates on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand/opcode presented
- in_ready  out  1  block can accept this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  4  opcode
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  operation result
- flags  out  4  {N,Z,C,V} for the result
- carry  out  1  architectural carry register (carry_q)

Behaviour:
- Reset (rst=1 at clk edge): s1_valid=0, out_valid=0, result=0, flags=0, carry_q=0; any in-flight ops are discarded.
- Pipeline:
  - S1 registers a/b/op.
  - S2 computes and registers result/flags.
  - Latency is 2 cycles from accept to out_valid, with no bubbles.
  - adv = !out_valid | out_ready; in_ready = adv (combinational, no dependence on in_valid).
  - Input accepted when in_valid & in_ready.
  - When adv=1, S1 moves to S2 and out_valid <= s1_valid.
  - When adv=0, both stages hold and result/flags stay stable.
- Opcodes (all arithmetic is modulo 2^WIDTH):
  - 0 CLR: 0
  - 1 ADD: a+b
  - 2 SUB: a-b
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 XNOR
  - 7 SET: all ones
  - 8 SHL: a << sh
  - 9 SHR: logical a >> sh
  - 10 SRA: arithmetic a >>> sh
  - 11 ADC: a+b+carry_q
  - 12 SBC: a-b-carry_q
  - 13 CMP: computes a-b for flags only; result = a
  - 14 PASSA: a
  - 15 PASSB: b
- Shift amount: sh = b[SHW-1:0]. If b >= WIDTH: SHL/SHR result is 0, SRA result is all copies of a[WIDTH-1].
- Flags:
  - N = result MSB; Z = (result == 0). For CMP, N and Z come from a-b, not from the result.
  - ADD/ADC: C = carry-out. SUB/SBC/CMP: C = borrow (1 when a < b+cin, unsigned).
  - V = signed overflow for ADD/ADC/SUB/SBC/CMP; C=V=0 for all other ops.
- carry_q:
  - Updated on the S1→S2 transfer, only for ops 1, 2, 11, 12, 13, with that op's C.
  - Other ops leave it unchanged.
  - Update order is program order: back-to-back ADC ops chain correctly with no stall.
- Back-pressure: with out_valid=1 and out_ready=0, nothing moves, carry_q holds, in_ready=0.
- Simultaneous drain and accept (out_ready=1, in_valid=1): full throughput of 1 op/cycle.
- Reset mid-stream clears both stages; no result from pre-reset input ever appears.
- No X on outputs after reset; the default opcode path does not exist (all 16 defined).

Test Plan:
- WIDTH=8, out_ready=1; ADD a=0xF0, b=0x20 → two cycles later result=0x10, C=1, V=0, Z=0, N=0; carry=1.
- Chained add: ADD 0xFF+0x01 then ADC 0x00+0x00 on consecutive cycles → results 0x00 (Z=1, C=1) then 0x01 (C=0); out_valid high two consecutive cycles.
- SUB 0x80-0x01 → 0x7F, V=1, C=0. CMP 0x05,0x07 → result 0x05, C=1, N=1, Z=0. Signed overflow ADD 0x7F+0x01 → 0x80, V=1, N=1.
- Shifts: SRA a=0x90, b=3 → 0xF2; SHR a=0x90, b=8 → 0x00; SRA a=0x90, b=9 → 0xFF; SHL a=0x81, b=1 → 0x02.
- Back-pressure: stream 4 ops, hold out_ready=0 for 3 cycles after the first result → in_ready=0, result/flags stable, no op lost or duplicated, order preserved.
- Reset with 2 ops in flight → out_valid=0 next cycle, carry=0, result=0; the next accepted op appears 2 cycles after acceptance.

Source files
------------

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready handshakes, status flags and an
// architectural carry register for multi-word add/subtract chains.
module alu_pipe #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             carry
);

    localparam logic [3:0] OP_CLR   = 4'd0;
    localparam logic [3:0] OP_ADD   = 4'd1;
    localparam logic [3:0] OP_SUB   = 4'd2;
    localparam logic [3:0] OP_AND   = 4'd3;
    localparam logic [3:0] OP_OR    = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_XNOR  = 4'd6;
    localparam logic [3:0] OP_SET   = 4'd7;
    localparam logic [3:0] OP_SHL   = 4'd8;
    localparam logic [3:0] OP_SHR   = 4'd9;
    localparam logic [3:0] OP_SRA   = 4'd10;
    localparam logic [3:0] OP_ADC   = 4'd11;
    localparam logic [3:0] OP_SBC   = 4'd12;
    localparam logic [3:0] OP_CMP   = 4'd13;
    localparam logic [3:0] OP_PASSA = 4'd14;
    localparam logic [3:0] OP_PASSB = 4'd15;

    localparam logic [WIDTH:0] WIDTH_V = (WIDTH+1)'(WIDTH);

    // Signed overflow of an addition: operands agree in sign, result does not.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb == b_msb) && (r_msb != a_msb);
    endfunction

    // Signed overflow of a subtraction: operands differ in sign, result follows b.
    function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
        return (a_msb != b_msb) && (r_msb != a_msb);
    endfunction

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_a_r;
    logic [WIDTH-1:0] s1_b_r;
    logic [3:0]       s1_op_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic [3:0]       flags_r;
    logic             carry_r;

    logic             adv_s;
    logic             cin_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   diff_s;
    logic             shift_big_s;
    logic [SHW-1:0]   sh_s;
    logic [WIDTH-1:0] shl_s;
    logic [WIDTH-1:0] shr_s;
    logic [WIDTH-1:0] sra_s;
    logic [WIDTH-1:0] res_s;
    logic [WIDTH-1:0] nz_src_s;
    logic             c_s;
    logic             v_s;
    logic             upd_carry_s;

    assign adv_s     = !out_valid_r || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign flags     = flags_r;
    assign carry     = carry_r;

    // Adder/subtractor and shifter datapath shared by all opcodes.
    always_comb begin
        if ((s1_op_r == OP_ADC) || (s1_op_r == OP_SBC)) begin
            cin_s = carry_r;
        end else begin
            cin_s = 1'b0;
        end
        sum_s       = {1'b0, s1_a_r} + {1'b0, s1_b_r} + {{WIDTH{1'b0}}, cin_s};
        diff_s      = {1'b0, s1_a_r} - {1'b0, s1_b_r} - {{WIDTH{1'b0}}, cin_s};
        shift_big_s = ({1'b0, s1_b_r} >= WIDTH_V);
        sh_s        = s1_b_r[SHW-1:0];
        if (shift_big_s) begin
            shl_s = {WIDTH{1'b0}};
            shr_s = {WIDTH{1'b0}};
            sra_s = {WIDTH{s1_a_r[WIDTH-1]}};
        end else begin
            shl_s = s1_a_r << sh_s;
            shr_s = s1_a_r >> sh_s;
            sra_s = $signed(s1_a_r) >>> sh_s;
        end
    end

    // Opcode decode: result, carry/borrow, overflow and N/Z source.
    always_comb begin
        res_s       = {WIDTH{1'b0}};
        c_s         = 1'b0;
        v_s         = 1'b0;
        upd_carry_s = 1'b0;
        case (s1_op_r)
            OP_CLR:   res_s = {WIDTH{1'b0}};
            OP_ADD, OP_ADC: begin
                res_s       = sum_s[WIDTH-1:0];
                c_s         = sum_s[WIDTH];
                v_s         = add_ovf(s1_a_r[WIDTH-1], s1_b_r[WIDTH-1], sum_s[WIDTH-1]);
                upd_carry_s = 1'b1;
            end
            OP_SUB, OP_SBC: begin
                res_s       = diff_s[WIDTH-1:0];
                c_s         = diff_s[WIDTH];
                v_s         = sub_ovf(s1_a_r[WIDTH-1], s1_b_r[WIDTH-1], diff_s[WIDTH-1]);
                upd_carry_s = 1'b1;
            end
            OP_CMP: begin
                res_s       = s1_a_r;
                c_s         = diff_s[WIDTH];
                v_s         = sub_ovf(s1_a_r[WIDTH-1], s1_b_r[WIDTH-1], diff_s[WIDTH-1]);
                upd_carry_s = 1'b1;
            end
            OP_AND:   res_s = s1_a_r & s1_b_r;
            OP_OR:    res_s = s1_a_r | s1_b_r;
            OP_XOR:   res_s = s1_a_r ^ s1_b_r;
            OP_XNOR:  res_s = ~(s1_a_r ^ s1_b_r);
            OP_SET:   res_s = {WIDTH{1'b1}};
            OP_SHL:   res_s = shl_s;
            OP_SHR:   res_s = shr_s;
            OP_SRA:   res_s = sra_s;
            OP_PASSA: res_s = s1_a_r;
            OP_PASSB: res_s = s1_b_r;
            default:  res_s = {WIDTH{1'b0}};
        endcase
        // CMP reports sign/zero of the difference, not of the passed-through operand.
        if (s1_op_r == OP_CMP) begin
            nz_src_s = diff_s[WIDTH-1:0];
        end else begin
            nz_src_s = res_s;
        end
    end

    // Stage 1: capture operands and opcode whenever the pipe advances.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {WIDTH{1'b0}};
            s1_b_r     <= {WIDTH{1'b0}};
            s1_op_r    <= 4'd0;
        end else if (adv_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_a_r  <= a;
                s1_b_r  <= b;
                s1_op_r <= op;
            end
        end
    end

    // Stage 2: register result/flags; carry_r updates in program order on transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            flags_r     <= 4'd0;
            carry_r     <= 1'b0;
        end else if (adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= res_s;
                flags_r  <= {nz_src_s[WIDTH-1], (nz_src_s == {WIDTH{1'b0}}), c_s, v_s};
                if (upd_carry_s) begin
                    carry_r <= c_s;
                end
            end
        end
    end

    alu_pipe_checker #(.WIDTH(WIDTH)) u_checker (
        .clk       (clk),
        .rst       (rst),
        .in_ready  (in_ready),
        .out_valid (out_valid_r),
        .out_ready (out_ready),
        .result    (result_r),
        .flags     (flags_r),
        .carry     (carry_r)
    );

endmodule

// Handshake and stall-stability properties for alu_pipe.
module alu_pipe_checker #(
    parameter int WIDTH = 8
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] result,
    input logic [3:0]       flags,
    input logic             carry
);

    a_ready_rule: assert property (@(posedge clk) disable iff (rst)
        in_ready == (!out_valid || out_ready))
        else $error("alu_pipe: in_ready does not follow out_valid/out_ready");

    a_stall_hold: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=>
        (out_valid && $stable(result) && $stable(flags) && $stable(carry)))
        else $error("alu_pipe: output changed while stalled");

    a_reset_clear: assert property (@(posedge clk)
        rst |=> (!out_valid && (carry == 1'b0) && (flags == 4'd0)))
        else $error("alu_pipe: reset did not clear outputs");

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe at WIDTH=8: opcode table, carry
// chaining, back-pressure and mid-stream reset.
module tb_alu_pipe;

    localparam int W = 8;

    typedef struct packed {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] res;
        logic [3:0]   fl;
        logic         cy;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic [3:0]   flags;
    logic         carry;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flags     (flags),
        .carry     (carry)
    );

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a = 8'h00; b = 8'h00; op = 4'd0;
        repeat (2) @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL reset_result got %h want 00", result); end
        n_vec++; if (flags !== 4'h0) begin n_err++; $display("FAIL reset_flags got %b want 0000", flags); end
        n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL reset_carry got %b want 0", carry); end
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_out_valid got %b want 0", out_valid); end
    endtask

    task automatic test_opcodes();
        vec_t v [0:24];
        // op, a, b, result, {N,Z,C,V}, carry after the op
        v[0]  = '{4'd1,  8'hF0, 8'h20, 8'h10, 4'b0010, 1'b1};
        v[1]  = '{4'd3,  8'hF0, 8'h3C, 8'h30, 4'b0000, 1'b1};
        v[2]  = '{4'd4,  8'h0F, 8'h30, 8'h3F, 4'b0000, 1'b1};
        v[3]  = '{4'd5,  8'hFF, 8'h0F, 8'hF0, 4'b1000, 1'b1};
        v[4]  = '{4'd6,  8'hA5, 8'hA5, 8'hFF, 4'b1000, 1'b1};
        v[5]  = '{4'd7,  8'h00, 8'h00, 8'hFF, 4'b1000, 1'b1};
        v[6]  = '{4'd0,  8'h12, 8'h34, 8'h00, 4'b0100, 1'b1};
        v[7]  = '{4'd14, 8'h80, 8'h01, 8'h80, 4'b1000, 1'b1};
        v[8]  = '{4'd15, 8'h80, 8'h01, 8'h01, 4'b0000, 1'b1};
        v[9]  = '{4'd11, 8'h10, 8'h20, 8'h31, 4'b0000, 1'b0};
        v[10] = '{4'd2,  8'h80, 8'h01, 8'h7F, 4'b0001, 1'b0};
        v[11] = '{4'd13, 8'h05, 8'h07, 8'h05, 4'b1010, 1'b1};
        v[12] = '{4'd12, 8'h10, 8'h05, 8'h0A, 4'b0000, 1'b0};
        v[13] = '{4'd12, 8'h00, 8'h00, 8'h00, 4'b0100, 1'b0};
        v[14] = '{4'd1,  8'h7F, 8'h01, 8'h80, 4'b1001, 1'b0};
        v[15] = '{4'd8,  8'h81, 8'h01, 8'h02, 4'b0000, 1'b0};
        v[16] = '{4'd9,  8'h90, 8'h08, 8'h00, 4'b0100, 1'b0};
        v[17] = '{4'd10, 8'h90, 8'h03, 8'hF2, 4'b1000, 1'b0};
        v[18] = '{4'd10, 8'h90, 8'h09, 8'hFF, 4'b1000, 1'b0};
        v[19] = '{4'd9,  8'h90, 8'h04, 8'h09, 4'b0000, 1'b0};
        v[20] = '{4'd12, 8'h00, 8'h01, 8'hFF, 4'b1010, 1'b1};
        v[21] = '{4'd8,  8'h01, 8'h07, 8'h80, 4'b1000, 1'b1};
        v[22] = '{4'd11, 8'hFF, 8'h00, 8'h00, 4'b0110, 1'b1};
        v[23] = '{4'd10, 8'h10, 8'h09, 8'h00, 4'b0100, 1'b1};
        v[24] = '{4'd11, 8'h7F, 8'h00, 8'h80, 4'b1001, 1'b0};
        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) begin
            op = v[i].op; a = v[i].a; b = v[i].b; in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            @(negedge clk);
            n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL op%0d_valid got %b want 1", i, out_valid); end
            n_vec++; if (result !== v[i].res) begin n_err++; $display("FAIL op%0d_result got %h want %h", i, result, v[i].res); end
            n_vec++; if (flags !== v[i].fl) begin n_err++; $display("FAIL op%0d_flags got %b want %b", i, flags, v[i].fl); end
            n_vec++; if (carry !== v[i].cy) begin n_err++; $display("FAIL op%0d_carry got %b want %b", i, carry, v[i].cy); end
        end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL opcodes_drain got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        op = 4'd1; a = 8'hFF; b = 8'h01; in_valid = 1'b1;
        @(negedge clk);
        op = 4'd11; a = 8'h00; b = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL chain0_valid got %b want 1", out_valid); end
        n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL chain0_result got %h want 00", result); end
        n_vec++; if (flags !== 4'b0110) begin n_err++; $display("FAIL chain0_flags got %b want 0110", flags); end
        n_vec++; if (carry !== 1'b1) begin n_err++; $display("FAIL chain0_carry got %b want 1", carry); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL chain1_valid got %b want 1", out_valid); end
        n_vec++; if (result !== 8'h01) begin n_err++; $display("FAIL chain1_result got %h want 01", result); end
        n_vec++; if (flags !== 4'b0000) begin n_err++; $display("FAIL chain1_flags got %b want 0000", flags); end
        n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL chain1_carry got %b want 0", carry); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL chain_drain got %b want 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] vals [4];
        logic [W-1:0] held_res;
        logic [3:0]   held_fl;
        logic         held_cy;
        int idx_in = 0;
        int idx_out = 0;
        int stall = 0;
        int cyc = 0;
        bit seen = 1'b0;
        bit held_set = 1'b0;
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};
        op = 4'd14; b = 8'h00;
        held_res = 8'h00; held_fl = 4'h0; held_cy = 1'b0;
        while (idx_out < 4 && cyc < 40) begin
            if (out_valid && !seen) begin
                seen = 1'b1; out_ready = 1'b1; stall = 3;
            end else if (stall > 0) begin
                out_ready = 1'b0; stall--;
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready) begin
                n_vec++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cyc%0d got %b want 0", cyc, in_ready); end
                n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL bp_out_valid cyc%0d got %b want 1", cyc, out_valid); end
                if (!held_set) begin
                    held_res = result; held_fl = flags; held_cy = carry; held_set = 1'b1;
                end else begin
                    n_vec++;
                    if (result !== held_res || flags !== held_fl || carry !== held_cy) begin
                        n_err++;
                        $display("FAIL bp_stable cyc%0d got %h/%b/%b want %h/%b/%b", cyc, result, flags, carry, held_res, held_fl, held_cy);
                    end
                end
            end
            if (out_valid && out_ready) begin
                n_vec++; if (result !== vals[idx_out]) begin n_err++; $display("FAIL bp_order%0d got %h want %h", idx_out, result, vals[idx_out]); end
                idx_out++;
            end
            if (idx_in < 4) begin
                in_valid = 1'b1; a = vals[idx_in];
                if (in_ready) idx_in++;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        n_vec++; if (idx_out != 4) begin n_err++; $display("FAIL bp_timeout got %0d results want 4", idx_out); end
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_duplicate got out_valid %b want 0", out_valid); end
        n_vec++; if (held_res !== 8'h22) begin n_err++; $display("FAIL bp_held_value got %h want 22", held_res); end
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b1;
        op = 4'd1; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
        @(negedge clk);
        op = 4'd1; a = 8'h01; b = 8'h02;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1 || carry !== 1'b1) begin n_err++; $display("FAIL mid_pre got valid %b carry %b want 1 1", out_valid, carry); end
        rst = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", out_valid); end
        n_vec++; if (carry !== 1'b0) begin n_err++; $display("FAIL mid_carry got %b want 0", carry); end
        n_vec++; if (result !== 8'h00) begin n_err++; $display("FAIL mid_result got %h want 00", result); end
        n_vec++; if (flags !== 4'h0) begin n_err++; $display("FAIL mid_flags got %b want 0000", flags); end
        rst = 1'b0;
        op = 4'd15; a = 8'h00; b = 8'h5A; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_leak got %b want 0", out_valid); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL post_valid got %b want 1", out_valid); end
        n_vec++; if (result !== 8'h5A) begin n_err++; $display("FAIL post_result got %h want 5a", result); end
        n_vec++; if (flags !== 4'b0000) begin n_err++; $display("FAIL post_flags got %b want 0000", flags); end
        @(negedge clk);
        n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL post_drain got %b want 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_opcodes();
        test_back_to_back();
        test_backpressure();
        test_reset_midstream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
